// File: rtl/regfile_mp.sv
// regfile_mp: parametrised multi-port register file with busy scoreboard.
//
// Two write ports (port 1 has priority on address collisions), NUM_RD fully
// independent combinational read ports with optional same-cycle write-to-read
// bypass, and an optional hardwired-zero register 0. A per-register busy bit
// tracks in-flight producers; busy_count is a registered popcount of those bits.
//
// Ports:
//   clk, rst                 rising-edge clock, synchronous active-high reset
//   read_reg / read_data     packed read addresses / data, port i at slice i
//   read_busy                busy flag of each read port's register
//   regWrite0/1, write_reg0/1, write_data0/1   the two write ports
//   reserve_en, reserve_reg  mark a register busy
//   busy_count               number of busy registers
module regfile_mp #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_RD   = 2,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_RD*ADDR_W-1:0] read_reg,
  output logic [NUM_RD*DATA_W-1:0] read_data,
  output logic [NUM_RD-1:0]        read_busy,
  input  logic                     regWrite0,
  input  logic [ADDR_W-1:0]        write_reg0,
  input  logic [DATA_W-1:0]        write_data0,
  input  logic                     regWrite1,
  input  logic [ADDR_W-1:0]        write_reg1,
  input  logic [DATA_W-1:0]        write_data1,
  input  logic                     reserve_en,
  input  logic [ADDR_W-1:0]        reserve_reg,
  output logic [ADDR_W:0]          busy_count
);

  localparam int DEPTH  = 2 ** ADDR_W;
  localparam bit ZERO_EN = (ZERO_REG != 0);
  localparam bit BYP_EN  = (BYPASS != 0);

  logic [DATA_W-1:0] regs_reg [DEPTH];
  logic [DEPTH-1:0]  busy_reg, busy_next;
  logic [ADDR_W:0]   busy_count_reg, busy_count_next;

  // Effective operations after dropping anything aimed at a hardwired zero register.
  logic wr0_ok, wr1_ok, res_ok;
  assign wr0_ok = regWrite0  && !(ZERO_EN && (write_reg0  == '0));
  assign wr1_ok = regWrite1  && !(ZERO_EN && (write_reg1  == '0));
  assign res_ok = reserve_en && !(ZERO_EN && (reserve_reg == '0));

  // Incremental count contributions. A clear is cancelled when the same register
  // is reserved this cycle (new producer wins), and when both write ports hit the
  // same register only one decrement is taken.
  logic up, dn0, dn1;
  always_comb begin
    up  = res_ok && !busy_reg[reserve_reg];
    dn0 = wr0_ok && busy_reg[write_reg0] && !(res_ok && (reserve_reg == write_reg0));
    dn1 = wr1_ok && busy_reg[write_reg1] && !(res_ok && (reserve_reg == write_reg1))
          && !(wr0_ok && (write_reg0 == write_reg1));
    busy_count_next = busy_count_reg + (ADDR_W+1)'(up) - (ADDR_W+1)'(dn0) - (ADDR_W+1)'(dn1);
  end

  // Clears first, then the reserve so a same-cycle reserve overrides a clear.
  always_comb begin
    busy_next = busy_reg;
    if (wr0_ok) busy_next[write_reg0] = 1'b0;
    if (wr1_ok) busy_next[write_reg1] = 1'b0;
    if (res_ok) busy_next[reserve_reg] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) regs_reg[i] <= '0;
      busy_reg       <= '0;
      busy_count_reg <= '0;
    end else begin
      // Port 1 is written last so it wins a same-address collision.
      if (wr0_ok) regs_reg[write_reg0] <= write_data0;
      if (wr1_ok) regs_reg[write_reg1] <= write_data1;
      busy_reg       <= busy_next;
      busy_count_reg <= busy_count_next;
    end
  end

  assign busy_count = busy_count_reg;

  for (genvar gi = 0; gi < NUM_RD; gi++) begin : g_rd
    logic [ADDR_W-1:0] addr;
    logic              is_zero, hit0, hit1;
    logic [DATA_W-1:0] data;
    logic              busy;

    assign addr    = read_reg[gi*ADDR_W +: ADDR_W];
    assign is_zero = ZERO_EN && (addr == '0);
    assign hit0    = BYP_EN && wr0_ok && (write_reg0 == addr);
    assign hit1    = BYP_EN && wr1_ok && (write_reg1 == addr);

    always_comb begin
      data = regs_reg[addr];
      busy = busy_reg[addr] && !(hit0 || hit1);
      if (hit0)    data = write_data0;
      if (hit1)    data = write_data1;
      if (is_zero) begin
        data = '0;
        busy = 1'b0;
      end
    end

    assign read_data[gi*DATA_W +: DATA_W] = data;
    assign read_busy[gi]                  = busy;
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Directed testbench for regfile_mp. Two instances share all inputs: one with
// bypass enabled (dut_b) and one without (dut_n), defaults otherwise.
module tb_regfile_mp;

  logic        clk = 1'b0;
  logic        rst;
  logic [9:0]  read_reg;
  logic        regWrite0, regWrite1, reserve_en;
  logic [4:0]  write_reg0, write_reg1, reserve_reg;
  logic [31:0] write_data0, write_data1;

  logic [63:0] rdata_b, rdata_n;
  logic [1:0]  rbusy_b, rbusy_n;
  logic [5:0]  count_b, count_n;

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  regfile_mp #(.BYPASS(1)) dut_b (
    .clk(clk), .rst(rst), .read_reg(read_reg), .read_data(rdata_b), .read_busy(rbusy_b),
    .regWrite0(regWrite0), .write_reg0(write_reg0), .write_data0(write_data0),
    .regWrite1(regWrite1), .write_reg1(write_reg1), .write_data1(write_data1),
    .reserve_en(reserve_en), .reserve_reg(reserve_reg), .busy_count(count_b));

  regfile_mp #(.BYPASS(0)) dut_n (
    .clk(clk), .rst(rst), .read_reg(read_reg), .read_data(rdata_n), .read_busy(rbusy_n),
    .regWrite0(regWrite0), .write_reg0(write_reg0), .write_data0(write_data0),
    .regWrite1(regWrite1), .write_reg1(write_reg1), .write_data1(write_data1),
    .reserve_en(reserve_en), .reserve_reg(reserve_reg), .busy_count(count_n));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end else begin
      $display("[TB] ok   %s: 0x%0h", tag, got);
    end
  endtask

  task automatic idle();
    regWrite0 = 1'b0; regWrite1 = 1'b0; reserve_en = 1'b0;
  endtask

  // Advance one edge; inputs change 1 time unit after it, checks 1 unit later.
  task automatic step();
    @(posedge clk);
    #1;
    idle();
  endtask

  task automatic rd(input logic [4:0] a0, input logic [4:0] a1);
    read_reg = {a1, a0};
    #1;
  endtask

  task automatic wr0(input logic [4:0] a, input logic [31:0] d);
    regWrite0 = 1'b1; write_reg0 = a; write_data0 = d;
  endtask

  task automatic wr1(input logic [4:0] a, input logic [31:0] d);
    regWrite1 = 1'b1; write_reg1 = a; write_data1 = d;
  endtask

  task automatic res(input logic [4:0] a);
    reserve_en = 1'b1; reserve_reg = a;
  endtask

  task automatic check_count(input string tag, input int exp);
    check({tag, "_cnt_b"}, 32'(count_b), 32'(exp));
    check({tag, "_cnt_n"}, 32'(count_n), 32'(exp));
  endtask

  initial begin
    idle();
    rst = 1'b1; read_reg = '0;
    write_reg0 = '0; write_reg1 = '0; reserve_reg = '0;
    write_data0 = '0; write_data1 = '0;

    // 1. reset
    step();
    rst = 1'b0;
    check_count("reset", 0);
    for (int a = 0; a < 32; a++) begin
      rd(5'(a), 5'(31 - a));
      check($sformatf("reset_rd_a%0d", a), rdata_b[31:0] | rdata_b[63:32] | rdata_n[31:0] | rdata_n[63:32], 32'h0);
      check($sformatf("reset_busy_a%0d", a), 32'({rbusy_b, rbusy_n}), 32'h0);
    end

    // 2. write-to-read bypass
    wr0(5'd1, 32'd55);
    rd(5'd0, 5'd1);
    check("byp_same_cycle_b", rdata_b[63:32], 32'd55);
    check("nobyp_same_cycle_n", rdata_n[63:32], 32'd0);
    step();
    rd(5'd0, 5'd1);
    check("byp_next_b", rdata_b[63:32], 32'd55);
    check("nobyp_next_n", rdata_n[63:32], 32'd55);

    // 3. dual write collision, port 1 wins; write to r0 dropped
    wr0(5'd7, 32'hAAAA); wr1(5'd7, 32'h5555);
    rd(5'd7, 5'd7);
    check("collide_byp_b", rdata_b[31:0], 32'h5555);
    step();
    rd(5'd7, 5'd7);
    check("collide_b", rdata_b[63:32], 32'h5555);
    check("collide_n", rdata_n[31:0], 32'h5555);
    wr0(5'd0, 32'hFFFFFFFF);
    rd(5'd0, 5'd0);
    check("r0_byp_b", rdata_b[31:0], 32'h0);
    step();
    rd(5'd0, 5'd0);
    check("r0_after_b", rdata_b[31:0], 32'h0);
    check("r0_after_n", rdata_n[63:32], 32'h0);

    // 4. reserve r3, r4; then write r3 + reserve r5
    res(5'd3);
    step();
    check_count("res_r3", 1);
    res(5'd4);
    step();
    check_count("res_r4", 2);
    rd(5'd3, 5'd4);
    check("busy_r3_r4_b", 32'(rbusy_b), 32'h3);
    wr0(5'd3, 32'h33); res(5'd5);
    rd(5'd3, 5'd5);
    check("busy_r3_hit_b", 32'(rbusy_b), 32'h0);
    check("busy_r3_nohit_n", 32'(rbusy_n), 32'h1);
    step();
    check_count("wr_r3_res_r5", 2);
    rd(5'd3, 5'd5);
    check("busy_r3_r5_b", 32'(rbusy_b), 32'h2);
    check("busy_r3_r5_n", 32'(rbusy_n), 32'h2);

    // 5. reserve + write same register; reserve r0
    res(5'd9); wr1(5'd9, 32'h12);
    step();
    rd(5'd9, 5'd9);
    check("r9_busy_b", 32'(rbusy_b), 32'h3);
    check("r9_data_n", rdata_n[31:0], 32'h12);
    check_count("r9_res_wr", 3);
    res(5'd0);
    step();
    rd(5'd0, 5'd9);
    check_count("res_r0", 3);
    check("r0_busy_b", 32'(rbusy_b), 32'h2);

    // Both ports clearing one busy register decrement the count once
    res(5'd12);
    step();
    res(5'd13);
    step();
    check_count("res_r12_r13", 5);
    wr0(5'd12, 32'h1); wr1(5'd12, 32'h2);
    step();
    check_count("dual_clear_same", 4);
    wr0(5'd13, 32'h3); wr1(5'd5, 32'h4);
    step();
    check_count("dual_clear_diff", 2);
    res(5'd10);
    step();
    check_count("three_busy", 3);

    // 6. reset mid-operation with an in-flight write
    rst = 1'b1; wr0(5'd11, 32'h77);
    step();
    rst = 1'b0;
    check_count("mid_reset", 0);
    rd(5'd11, 5'd7);
    check("mid_reset_r11_b", rdata_b[31:0], 32'h0);
    check("mid_reset_r7_n", rdata_n[63:32], 32'h0);
    rd(5'd4, 5'd10);
    check("mid_reset_busy_b", 32'(rbusy_b), 32'h0);
    rd(5'd1, 5'd9);
    check("mid_reset_r1_r9", rdata_b[31:0] | rdata_n[63:32], 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
